// File: rtl/game_state_ctrl.sv
// game_state_ctrl
//   Top-level game sequencer. Walks START -> GAME -> PLAYER_1/PLAYER_2 -> START,
//   keeps per-player scores, issues a one-cycle round_rst pulse whenever the
//   players must respawn, and masks hits for a number of frames after each
//   respawn.
//
// Ports
//   clk        in   65 MHz pixel clock
//   rst_n      in   synchronous reset, active low
//   vblnk      in   vertical blank level from the timing generator
//   btn_start  in   start button level, already synchronised to clk
//   p1_hit     in   1-cycle pulse, player 1 scored on player 2
//   p2_hit     in   1-cycle pulse, player 2 scored on player 1
//   state_out  out  current state (START=0, GAME=1, PLAYER_1=2, PLAYER_2=3)
//   score_p1   out  player 1 score, unsigned
//   score_p2   out  player 2 score, unsigned
//   round_rst  out  1-cycle respawn / terrain reset pulse
//   hit_lock   out  high while hits are ignored after a respawn
module game_state_ctrl #(
  parameter int WIN_SCORE   = 5,
  parameter int LOCK_FRAMES = 30,
  parameter int HOLD_FRAMES = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblnk,
  input  logic       btn_start,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic [1:0] state_out,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       round_rst,
  output logic       hit_lock
);

  typedef enum logic [1:0] {
    START    = 2'd0,
    GAME     = 2'd1,
    PLAYER_1 = 2'd2,
    PLAYER_2 = 2'd3
  } state_t;

  localparam logic [3:0] WIN  = 4'(WIN_SCORE);
  localparam logic [7:0] LOCK = 8'(LOCK_FRAMES);
  localparam logic [9:0] HOLD = 10'(HOLD_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [7:0] lock_q, lock_d;
  logic [9:0] hold_q, hold_d;
  logic       rr_q, rr_d;
  logic       lockflag_q;
  logic       btn_prev, vblnk_prev;
  logic       frame_tick, start_rise;

  // Previous-sample registers reset high so a level already asserted when
  // reset releases is not mistaken for a fresh edge.
  assign frame_tick = vblnk & ~vblnk_prev;
  assign start_rise = btn_start & ~btn_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= START;
      score1_q   <= '0;
      score2_q   <= '0;
      lock_q     <= '0;
      hold_q     <= '0;
      rr_q       <= 1'b0;
      lockflag_q <= 1'b0;
      btn_prev   <= 1'b1;
      vblnk_prev <= 1'b1;
    end else begin
      state_q    <= state_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      lock_q     <= lock_d;
      hold_q     <= hold_d;
      rr_q       <= rr_d;
      // Registered copy of (lock_cnt != 0) so hit_lock tracks the counter
      // with no extra cycle of lag; only meaningful while playing.
      lockflag_q <= (state_d == GAME) && (lock_d != 8'd0);
      btn_prev   <= btn_start;
      vblnk_prev <= vblnk;
    end
  end

  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    lock_d   = lock_q;
    hold_d   = hold_q;
    rr_d     = 1'b0;

    unique case (state_q)
      START: begin
        score1_d = '0;
        score2_d = '0;
        if (start_rise) begin
          state_d = GAME;
          rr_d    = 1'b1;
          lock_d  = LOCK;
        end
      end

      GAME: begin
        if (lock_q != 8'd0) begin
          if (frame_tick) lock_d = lock_q - 8'd1;
        end else if (p1_hit || p2_hit) begin
          // Any accepted hit respawns and re-arms protection; a reload
          // overrides a coincident frame tick.
          rr_d   = 1'b1;
          lock_d = LOCK;
          if (p1_hit && !p2_hit) begin
            score1_d = score1_q + 4'd1;
            if (score1_q + 4'd1 == WIN) begin
              state_d = PLAYER_1;
              hold_d  = '0;
            end
          end else if (p2_hit && !p1_hit) begin
            score2_d = score2_q + 4'd1;
            if (score2_q + 4'd1 == WIN) begin
              state_d = PLAYER_2;
              hold_d  = '0;
            end
          end
        end
      end

      PLAYER_1, PLAYER_2: begin
        if (start_rise) begin
          state_d  = START;
          score1_d = '0;
          score2_d = '0;
          hold_d   = '0;
        end else if (frame_tick) begin
          if (hold_q + 10'd1 == HOLD) begin
            state_d  = START;
            score1_d = '0;
            score2_d = '0;
            hold_d   = '0;
          end else begin
            hold_d = hold_q + 10'd1;
          end
        end
      end

      default: state_d = START;
    endcase
  end

  assign state_out = state_q;
  assign score_p1  = score1_q;
  assign score_p2  = score2_q;
  assign round_rst = rr_q;
  assign hit_lock  = lockflag_q;

endmodule
